// File: rtl/kempston_mouse_ex.sv
// Kempston mouse port: two-stage packet pipeline, residue-carrying sensitivity scaling,
// one-shot button swap detection and port decode. Optional wheel nibble: define MOUSE_WHEEL_EN.
module kempston_mouse_ex #(
    parameter int COORD_W    = 12,
    parameter int SENS_SHIFT = 0,
    parameter int Y_INV      = 0
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [24:0]        ps2_mouse,
    input  logic [3:0]         wheel_delta,
    input  logic [2:0]         addr,
    output logic               sel,
    output logic [7:0]         dout,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y
);
    localparam int ACC_W = 11;
    localparam int RES_W = (SENS_SHIFT > 0) ? SENS_SHIFT : 1;

    typedef enum logic {
        SW_DETECT = 1'b0,
        SW_LOCKED = 1'b1
    } sw_state_t;

    // Residue is non-negative and below 2^SENS_SHIFT, delta is a signed 10-bit value.
    function automatic logic [ACC_W-1:0] axis_acc(input logic [RES_W-1:0] res,
                                                  input logic [9:0]       delta);
        return {{(ACC_W-RES_W){1'b0}}, res} + {{(ACC_W-10){delta[9]}}, delta};
    endfunction

    logic                toggle_q;
    logic                event_s;

    logic                s1_valid_q, s1_valid_d;
    logic [8:0]          s1_dx_q, s1_dx_d;
    logic [8:0]          s1_dy_q, s1_dy_d;
    logic [2:0]          s1_btn_q, s1_btn_d;

    logic [COORD_W-1:0]  pos_x_q, pos_x_d;
    logic [COORD_W-1:0]  pos_y_q, pos_y_d;
    logic [RES_W-1:0]    res_x_q, res_x_d;
    logic [RES_W-1:0]    res_y_q, res_y_d;
    logic [2:0]          btn_rep_q, btn_rep_d;

    sw_state_t           state_q;
    logic [1:0]          swap_q;
    logic [1:0]          swap_eff_s;
    logic [1:0]          lr_s;

    logic [9:0]          dy_ext_s;
    logic signed [ACC_W-1:0] acc_x_s, acc_y_s;
    logic signed [ACC_W-1:0] step_x_s, step_y_s;
    logic [7:0]          btn_byte_s;
    logic                unused_s;

`ifdef MOUSE_WHEEL_EN
    logic [3:0]          s1_whl_q, s1_whl_d;
    logic [3:0]          whl_q, whl_d;
`endif

    assign event_s = ps2_mouse[24] ^ toggle_q;

    // Toggle history samples even during reset so a level held across release is not an event.
    always_ff @(posedge clk_sys) begin
        toggle_q <= ps2_mouse[24];
    end

    // Stage 1: capture the packet fields on an event cycle.
    always_comb begin
        s1_valid_d = event_s;
        s1_dx_d    = s1_dx_q;
        s1_dy_d    = s1_dy_q;
        s1_btn_d   = s1_btn_q;
`ifdef MOUSE_WHEEL_EN
        s1_whl_d   = s1_whl_q;
`endif
        if (event_s) begin
            s1_dx_d  = {ps2_mouse[4], ps2_mouse[15:8]};
            s1_dy_d  = {ps2_mouse[5], ps2_mouse[23:16]};
            s1_btn_d = ps2_mouse[2:0];
`ifdef MOUSE_WHEEL_EN
            s1_whl_d = wheel_delta;
`endif
        end else begin
            s1_dx_d  = s1_dx_q;
        end
    end

    // Stage 1 registers; reset drops any packet in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_dx_q    <= 9'd0;
            s1_dy_q    <= 9'd0;
            s1_btn_q   <= 3'd0;
`ifdef MOUSE_WHEEL_EN
            s1_whl_q   <= 4'd0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_btn_q   <= s1_btn_d;
`ifdef MOUSE_WHEEL_EN
            s1_whl_q   <= s1_whl_d;
`endif
        end
    end

    // Y inversion uses 10 bits so that -256 becomes +256.
    always_comb begin
        if (Y_INV != 0) begin
            dy_ext_s = 10'd0 - {s1_dy_q[8], s1_dy_q};
        end else begin
            dy_ext_s = {s1_dy_q[8], s1_dy_q};
        end
    end

    // Stage 2: scale motion with residue carry, update counters and reported buttons.
    always_comb begin
        acc_x_s    = axis_acc(res_x_q, {s1_dx_q[8], s1_dx_q});
        acc_y_s    = axis_acc(res_y_q, dy_ext_s);
        step_x_s   = acc_x_s >>> SENS_SHIFT;
        step_y_s   = acc_y_s >>> SENS_SHIFT;
        lr_s       = s1_btn_q[1:0];
        swap_eff_s = swap_q;
        if ((state_q == SW_DETECT) && (lr_s != 2'b00)) begin
            swap_eff_s = lr_s;
        end else begin
            swap_eff_s = swap_q;
        end
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        res_x_d   = res_x_q;
        res_y_d   = res_y_q;
        btn_rep_d = btn_rep_q;
`ifdef MOUSE_WHEEL_EN
        whl_d     = whl_q;
`endif
        if (s1_valid_q) begin
            pos_x_d   = pos_x_q + COORD_W'(step_x_s);
            pos_y_d   = pos_y_q + COORD_W'(step_y_s);
            btn_rep_d = {s1_btn_q[2], lr_s[~swap_eff_s[1]], lr_s[swap_eff_s[1]]};
            if (SENS_SHIFT > 0) begin
                res_x_d = acc_x_s[RES_W-1:0];
                res_y_d = acc_y_s[RES_W-1:0];
            end else begin
                res_x_d = {RES_W{1'b0}};
                res_y_d = {RES_W{1'b0}};
            end
`ifdef MOUSE_WHEEL_EN
            whl_d     = whl_q + s1_whl_q;
`endif
        end else begin
            pos_x_d = pos_x_q;
        end
    end

    // Stage 2 registers; pos_x resets to 128 so the two axes are distinguishable.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos_x_q   <= COORD_W'(8'd128);
            pos_y_q   <= {COORD_W{1'b0}};
            res_x_q   <= {RES_W{1'b0}};
            res_y_q   <= {RES_W{1'b0}};
            btn_rep_q <= 3'd0;
`ifdef MOUSE_WHEEL_EN
            whl_q     <= 4'd0;
`endif
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            res_x_q   <= res_x_d;
            res_y_q   <= res_y_d;
            btn_rep_q <= btn_rep_d;
`ifdef MOUSE_WHEEL_EN
            whl_q     <= whl_d;
`endif
        end
    end

    // Button swap FSM: the first packet with left or right pressed fixes the mapping until reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= SW_DETECT;
            swap_q  <= 2'b00;
        end else if (s1_valid_q) begin
            case (state_q)
                SW_DETECT: begin
                    if (lr_s != 2'b00) begin
                        swap_q  <= lr_s;
                        state_q <= SW_LOCKED;
                    end else begin
                        state_q <= SW_DETECT;
                    end
                end
                SW_LOCKED: state_q <= SW_LOCKED;
                default:   state_q <= SW_DETECT;
            endcase
        end else begin
            state_q <= state_q;
        end
    end

`ifdef MOUSE_WHEEL_EN
    assign btn_byte_s = {whl_q, 1'b1, ~btn_rep_q};
    assign unused_s   = ^{ps2_mouse[7:6], ps2_mouse[3]};
`else
    assign btn_byte_s = {5'b11111, ~btn_rep_q};
    assign unused_s   = ^{ps2_mouse[7:6], ps2_mouse[3], wheel_delta};
`endif

    // Port decode; unmatched addresses float the bus high.
    always_comb begin
        sel  = 1'b0;
        dout = 8'hFF;
        case (addr)
            3'b011: begin
                sel  = 1'b1;
                dout = pos_x_q[7:0];
            end
            3'b111: begin
                sel  = 1'b1;
                dout = pos_y_q[7:0];
            end
            3'b010, 3'b110: begin
                sel  = 1'b1;
                dout = btn_byte_s;
            end
            default: begin
                sel  = 1'b0;
                dout = 8'hFF;
            end
        endcase
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;

endmodule

// File: tb/tb_kempston_mouse_ex.sv
// Directed bench for kempston_mouse_ex: default instance (A) and SENS_SHIFT=2/Y_INV=1 instance (B).
module tb_kempston_mouse_ex;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [24:0] ps2_a, ps2_b;
    logic [3:0]  wheel_a, wheel_b;
    logic [2:0]  addr_a, addr_b;
    logic        sel_a, sel_b;
    logic [7:0]  dout_a, dout_b;
    logic [11:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    int          total = 0;
    int          bad = 0;

    always #5 clk_sys = ~clk_sys;

    kempston_mouse_ex #(.COORD_W(12), .SENS_SHIFT(0), .Y_INV(0)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_a), .wheel_delta(wheel_a),
        .addr(addr_a), .sel(sel_a), .dout(dout_a), .pos_x(pos_x_a), .pos_y(pos_y_a)
    );

    kempston_mouse_ex #(.COORD_W(12), .SENS_SHIFT(2), .Y_INV(1)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_b), .wheel_delta(wheel_b),
        .addr(addr_b), .sel(sel_b), .dout(dout_b), .pos_x(pos_x_b), .pos_y(pos_y_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected button byte from the wheel nibble and the three active-low button bits.
    function automatic logic [7:0] exp_byte(input logic [3:0] whl, input logic [2:0] low);
`ifdef MOUSE_WHEEL_EN
        return {whl, 1'b1, low};
`else
        return {5'b11111, low};
`endif
    endfunction

    task automatic pkt_a(input int dx, input int dy, input logic [2:0] btn, input logic [3:0] whl);
        logic [8:0] x9;
        logic [8:0] y9;
        x9 = dx[8:0];
        y9 = dy[8:0];
        ps2_a   = {~ps2_a[24], y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, btn};
        wheel_a = whl;
    endtask

    task automatic pkt_b(input int dx, input int dy);
        logic [8:0] x9;
        logic [8:0] y9;
        x9 = dx[8:0];
        y9 = dy[8:0];
        ps2_b = {~ps2_b[24], y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 1'b0, 3'b000};
    endtask

    task automatic wait_pipe();
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        reset   = 1'b1;
        ps2_a   = 25'd0;
        ps2_b   = 25'd0;
        wheel_a = 4'd0;
        wheel_b = 4'd0;
        addr_a  = 3'b000;
        addr_b  = 3'b000;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        // Reset state and decode
        addr_a = 3'b011; #1;
        check_eq("rst_x_byte", dout_a, 32'h80);
        check_eq("rst_x_sel", sel_a, 32'd1);
        addr_a = 3'b111; #1;
        check_eq("rst_y_byte", dout_a, 32'h00);
        addr_a = 3'b010; #1;
        check_eq("rst_btn_byte", dout_a, exp_byte(4'h0, 3'b111));
        addr_a = 3'b000; #1;
        check_eq("nosel_sel", sel_a, 32'd0);
        check_eq("nosel_dout", dout_a, 32'hFF);
        check_eq("rst_pos_x", pos_x_a, 32'd128);
        check_eq("rst_pos_y", pos_y_a, 32'd0);

        // dx=+5, dy=-3 with two-cycle latency
        pkt_a(5, -3, 3'b000, 4'h0);
        @(negedge clk_sys);
        check_eq("lat1_pos_x", pos_x_a, 32'd128);
        @(negedge clk_sys);
        check_eq("mv_pos_x", pos_x_a, 32'd133);
        check_eq("mv_pos_y", pos_y_a, 32'd4093);

        // Zero motion still updates buttons; middle is not swapped
        pkt_a(0, 0, 3'b100, 4'h0);
        wait_pipe();
        check_eq("zero_pos_x", pos_x_a, 32'd133);
        addr_a = 3'b110; #1;
        check_eq("mid_btn_byte", dout_a, exp_byte(4'h0, 3'b011));

        // Swap detection: right-only first press maps right to left
        pkt_a(0, 0, 3'b010, 4'h0);
        wait_pipe();
        pkt_a(0, 0, 3'b010, 4'h0);
        wait_pipe();
        addr_a = 3'b110; #1;
        check_eq("swap_byte", dout_a, exp_byte(4'h0, 3'b110));
        pkt_a(0, 0, 3'b001, 4'h0);
        wait_pipe();
        addr_a = 3'b010; #1;
        check_eq("swap_locked_byte", dout_a, exp_byte(4'h0, 3'b101));

        // Toggle flipped during reset must not cause an event after release
        reset = 1'b1;
        @(negedge clk_sys);
        pkt_a(5, 0, 3'b000, 4'h0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_eq("rst_hist_pos_x", pos_x_a, 32'd128);

        // Back-to-back packets, then reset kills the fourth in flight
        pkt_a(1, 0, 3'b000, 4'h0);
        @(negedge clk_sys);
        pkt_a(1, 0, 3'b000, 4'h0);
        @(negedge clk_sys);
        pkt_a(1, 0, 3'b000, 4'h0);
        @(negedge clk_sys);
        pkt_a(1, 0, 3'b000, 4'h0);
        @(negedge clk_sys);
        check_eq("b2b_pos_x", pos_x_a, 32'd131);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check_eq("flush_pos_x", pos_x_a, 32'd128);

        // Swap FSM restarts after reset: left-only press is a straight mapping
        pkt_a(0, 0, 3'b001, 4'h0);
        wait_pipe();
        addr_a = 3'b010; #1;
        check_eq("swap_rst_byte", dout_a, exp_byte(4'h0, 3'b110));

        // Wrap on both axes
        do_reset();
        pkt_a(-200, -1, 3'b000, 4'h0);
        wait_pipe();
        check_eq("wrap_pos_y", pos_y_a, 32'd4095);
        check_eq("wrap_pos_x", pos_x_a, 32'd4024);

`ifdef MOUSE_WHEEL_EN
        pkt_a(0, 0, 3'b000, 4'hF);
        wait_pipe();
        addr_a = 3'b010; #1;
        check_eq("wheel_neg", dout_a, 32'hFF);
        pkt_a(0, 0, 3'b000, 4'h2);
        wait_pipe();
        addr_a = 3'b010; #1;
        check_eq("wheel_wrap", dout_a, 32'h1F);
`endif

        // Instance B: SENS_SHIFT=2 residue carry and inverted Y
        do_reset();
        pkt_b(1, 0);
        wait_pipe();
        check_eq("s2_p1", pos_x_b, 32'd128);
        pkt_b(1, 0);
        wait_pipe();
        check_eq("s2_p2", pos_x_b, 32'd128);
        pkt_b(1, 0);
        wait_pipe();
        check_eq("s2_p3", pos_x_b, 32'd128);
        pkt_b(1, 0);
        wait_pipe();
        check_eq("s2_p4", pos_x_b, 32'd129);
        pkt_b(-1, 0);
        wait_pipe();
        check_eq("s2_neg", pos_x_b, 32'd128);
        pkt_b(1, 0);
        wait_pipe();
        check_eq("s2_res3", pos_x_b, 32'd129);
        pkt_b(0, -256);
        wait_pipe();
        check_eq("yinv_256", pos_y_b, 32'd64);
        addr_b = 3'b111; #1;
        check_eq("yinv_byte", dout_b, 32'h40);
        check_eq("yinv_sel", sel_b, 32'd1);
        pkt_b(0, 4);
        wait_pipe();
        check_eq("yinv_pos4", pos_y_b, 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kempston_mouse_ex.md
KEMPSTON_MOUSE_EX -- requirements
Module: kempston_mouse_ex

Interface
REQ-001 Parameter COORD_W, default 12: width of internal X/Y position counters; legal range 8..16.
REQ-002 Parameter SENS_SHIFT, default 0: motion divided by 2^SENS_SHIFT with residue carry; legal range 0..3.
REQ-003 Parameter Y_INV, default 0: 1 = negate Y motion before scaling.
REQ-004 clk_sys  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ps2_mouse  input  25  [24] toggle strobe, [23:16] dy, [15:8] dx, [5] dy sign, [4] dx sign, [2:0] middle/right/left buttons.
REQ-007 wheel_delta  input  4  signed wheel motion; qualified by the same toggle as ps2_mouse.
REQ-008 addr  input  3  port address select.
REQ-009 sel  output  1  high when addr decodes to a mouse port.
REQ-010 dout  output  8  port read data.
REQ-011 pos_x, pos_y  output  COORD_W each  full-width position counters.

Function
REQ-012 Packet event SHALL be any cycle where ps2_mouse[24] differs from its value registered on the previous cycle.
REQ-013 Stage 1 SHALL register the packet (9-bit signed dx/dy, buttons, wheel_delta) on the event cycle; stage 2 SHALL update counters next cycle; pos_x/pos_y/dout reflect a packet 2 cycles after the toggle change.
REQ-014 Pipeline SHALL accept one packet per cycle; back-to-back toggles every cycle SHALL lose no packet.
REQ-015 Per axis: acc = residue + delta (sign-extended); step = acc arithmetic-shifted right by SENS_SHIFT; residue = acc - step*2^SENS_SHIFT (always 0..2^SENS_SHIFT-1); counter += step.
REQ-016 SENS_SHIFT=0: step equals delta; residue stays 0.
REQ-017 Counters SHALL wrap modulo 2^COORD_W; no saturation.
REQ-018 Y_INV=1: dy negated (9-bit two's complement; -256 treated as +256 with 10-bit intermediate) before REQ-015.
REQ-019 Button swap FSM, states SW_DETECT, SW_LOCKED: in SW_DETECT the first packet with buttons[1:0] != 0 loads swap = buttons[1:0] and moves to SW_LOCKED; SW_LOCKED holds until reset.
REQ-020 Reported bit0 = button[swap[1]], bit1 = button[~swap[1]]; middle button unswapped; buttons updated on every packet.
REQ-021 Decode (combinational): addr 011 -> pos_x[7:0]; 111 -> pos_y[7:0]; x10 -> button byte; sel=1 for these.
REQ-022 Button byte: bit0..2 = inverted reported left/right/middle (pressed reads 0); bits 7:3 per REQ-029/030.
REQ-023 Other addr: sel=0, dout=8'hFF.
REQ-024 Packet with dx=dy=0 SHALL still update buttons and wheel; counters unchanged, residue unchanged.

Reset
REQ-025 Reset SHALL set pos_x=128, pos_y=0 (distinct for detection), residues 0, buttons 0, wheel 0, FSM SW_DETECT, stage-1 valid 0.
REQ-026 Toggle history register SHALL keep sampling during reset so toggle state at reset release causes no spurious event.
REQ-027 Packet in flight when reset asserts SHALL be discarded.
REQ-028 Reset has priority over a simultaneous packet event.

Configuration
REQ-029 MOUSE_WHEEL_EN defined: 4-bit wheel counter adds wheel_delta per packet, wraps mod 16; button byte bits 7:4 = wheel counter, bit3 = 1.
REQ-030 MOUSE_WHEEL_EN undefined: wheel_delta ignored, no wheel register; button byte bits 7:3 = 5'b11111.

Verification
REQ-031 After reset, addr=011 -> dout=0x80, sel=1; addr=111 -> 0x00; addr=010 -> 0xFF (wheel off) / 0x0F... bits7:4=0 with wheel on (0x0F).
REQ-032 SENS_SHIFT=0: toggle with dx=+5, dy=-3 (byte 0xFD, sign 1) -> 2 cycles later pos_x=133, pos_y=4093 (COORD_W=12).
REQ-033 SENS_SHIFT=2: four packets dx=+1 -> pos_x 128,128,128,129; then dx=-1 -> pos_x 128, residue 3.
REQ-034 First packet buttons=2'b10, then packet buttons=2'b10 -> addr=110 dout bit0=0, bit1=1 (right mapped to left); later 2'b01 leaves swap locked.
REQ-035 Toggle flipped 3 consecutive cycles with dx=+1 each -> pos_x=131; reset asserted one cycle after a fourth toggle -> pos_x=128, no later increment.
REQ-036 MOUSE_WHEEL_EN: wheel_delta=-1 from reset -> button byte bits 7:4 = 4'hF; pos_y wrap: dy=-1 from 0 -> pos_y=2^COORD_W-1.
